// File: rtl/elevator_shaft_model.sv
// Plant model of an elevator car, shaft and door: turns motor/door commands into
// floor-sensor pulses and flags command sequences a real shaft could not follow.
module elevator_shaft_model #(
   parameter int unsigned TRAVEL_CYCLES = 5,
   parameter int unsigned DOOR_CYCLES   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] ac,
   input  logic       door_open,
   output logic       s1,
   output logic       s2,
   output logic       s3,
   output logic [1:0] position,
   output logic       moving,
   output logic       door_busy,
   output logic       fault
);

   localparam int unsigned TW = $clog2(TRAVEL_CYCLES);
   localparam int unsigned DW = $clog2(DOOR_CYCLES + 2);

   localparam logic [1:0] AC_UP   = 2'b01;
   localparam logic [1:0] AC_DOWN = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      TRAVEL_UP,
      TRAVEL_DOWN,
      DOOR,
      FAULT
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [DW-1:0]   dcnt_q, dcnt_d;
   logic [1:0]      pos_q, pos_d;
   logic [2:0]      sens_q, sens_d;
   logic            moving_q, moving_d;
   logic            busy_q, busy_d;
   logic            fault_q, fault_d;

   // Next-state, counters and registered-output decode
   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      dcnt_d  = dcnt_q;
      pos_d   = pos_q;
      sens_d  = 3'b000;

      unique case (state_q)
         IDLE: begin
            if (door_open) begin
               state_d = DOOR;
               dcnt_d  = DW'(DOOR_CYCLES);
            end else if (ac == AC_UP) begin
               if (pos_q != 2'd3) begin
                  state_d = TRAVEL_UP;
                  tcnt_d  = TW'(TRAVEL_CYCLES - 1);
               end else begin
                  state_d = FAULT;
               end
            end else if (ac == AC_DOWN) begin
               if (pos_q != 2'd1) begin
                  state_d = TRAVEL_DOWN;
                  tcnt_d  = TW'(TRAVEL_CYCLES - 1);
               end else begin
                  state_d = FAULT;
               end
            end
         end
         TRAVEL_UP: begin
            if (door_open || ac == AC_DOWN) begin
               state_d = FAULT;
            end else if (tcnt_q == '0) begin
               state_d = IDLE;
               pos_d   = pos_q + 2'd1;
               sens_d  = {pos_d == 2'd3, pos_d == 2'd2, pos_d == 2'd1};
            end else begin
               tcnt_d = tcnt_q - TW'(1);
            end
         end
         TRAVEL_DOWN: begin
            if (door_open || ac == AC_UP) begin
               state_d = FAULT;
            end else if (tcnt_q == '0) begin
               state_d = IDLE;
               pos_d   = pos_q - 2'd1;
               sens_d  = {pos_d == 2'd3, pos_d == 2'd2, pos_d == 2'd1};
            end else begin
               tcnt_d = tcnt_q - TW'(1);
            end
         end
         DOOR: begin
            // Motion commands are held off here and re-evaluated once back in IDLE
            if (door_open) begin
               dcnt_d = DW'(DOOR_CYCLES);
            end else if (dcnt_q == '0) begin
               state_d = IDLE;
            end else begin
               dcnt_d = dcnt_q - DW'(1);
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = FAULT;
         end
      endcase

      moving_d = (state_d == TRAVEL_UP) || (state_d == TRAVEL_DOWN);
      busy_d   = (state_d == DOOR);
      fault_d  = (state_d == FAULT);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         tcnt_q   <= '0;
         dcnt_q   <= '0;
         pos_q    <= 2'd1;
         sens_q   <= 3'b000;
         moving_q <= 1'b0;
         busy_q   <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         tcnt_q   <= tcnt_d;
         dcnt_q   <= dcnt_d;
         pos_q    <= pos_d;
         sens_q   <= sens_d;
         moving_q <= moving_d;
         busy_q   <= busy_d;
         fault_q  <= fault_d;
      end
   end

   assign s1        = sens_q[0];
   assign s2        = sens_q[1];
   assign s3        = sens_q[2];
   assign position  = pos_q;
   assign moving    = moving_q;
   assign door_busy = busy_q;
   assign fault     = fault_q;

endmodule
